// File: rtl/lfsr_prng_stream_if.sv
// Valid/ready word stream carrying pseudo-random output words.
interface lfsr_prng_stream_if #(
    parameter int OUT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_prng_stream.sv
// Parametrised Fibonacci/Galois LFSR generator that advances OUT_W shifts per word
// and delivers words over a valid/ready stream with reseed and lockup recovery.
module lfsr_prng_stream #(
    parameter int               WIDTH = 64,
    parameter int               OUT_W = 32,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] TAPS  = 64'hD800000000000000,
    parameter logic [WIDTH-1:0] SEED  = 64'hDEADBEEF12345678,
    parameter int               CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      seed_load,
    input  logic [WIDTH-1:0]          seed_data,
    lfsr_prng_stream_if.master        stream,
    output logic [WIDTH-1:0]          state_out,
    output logic [CNT_W-1:0]          word_cnt
);

    if (WIDTH < 2) begin : g_bad_width
        $error("lfsr_prng_stream: WIDTH must be at least 2");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_prng_stream: OUT_W must be within 1..WIDTH");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_prng_stream: SEED has no bits set inside WIDTH");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("lfsr_prng_stream: MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] adv_st;
    logic             xfer;
    logic             advance;
    logic             lockup;

    assign xfer      = stream.out_valid & stream.out_ready;
    assign advance   = enable & (~stream.out_valid | stream.out_ready) & ~seed_load;
    assign lockup    = (st == '0);
    assign state_out = st;

    // All OUT_W single-bit shifts unrolled into one combinational step.
    always_comb begin
        adv_st = st;
        for (int i = 0; i < OUT_W; i++) begin
            if (MODE == 0) begin
                adv_st = {adv_st[WIDTH-2:0], ^(adv_st & TAPS)};
            end else begin
                adv_st = (adv_st >> 1) ^ (adv_st[0] ? TAPS : '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st               <= SEED;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            word_cnt         <= '0;
        end else if (seed_load) begin
            st               <= (seed_data == '0) ? SEED : seed_data;
            stream.out_valid <= 1'b0;
            word_cnt         <= '0;
        end else begin
            if (xfer && !(&word_cnt)) begin
                word_cnt <= word_cnt + 1'b1;
            end
            // An all-zero state would never leave zero; recover from SEED.
            if (lockup) begin
                st               <= SEED;
                stream.out_valid <= 1'b0;
            end else if (advance) begin
                st               <= adv_st;
                stream.out_data  <= adv_st[OUT_W-1:0];
                stream.out_valid <= 1'b1;
            end else if (xfer) begin
                stream.out_valid <= 1'b0;
            end
        end
    end

endmodule
